// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round controller: mole relocation, guess window, wrong-guess
// lockout, score keeping and the seconds countdown to game over.
module mole_game_ctrl #(
   parameter int unsigned MOLE_TICKS    = 8,
   parameter int unsigned LOCK_TICKS    = 4,
   parameter int unsigned TICKS_PER_SEC = 4,
   parameter int unsigned GAME_SECONDS  = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       restart_game,
   input  logic       eval_now,
   input  logic [2:0] user_guess,
   input  logic [2:0] rand_pos,
   output logic [2:0] mole_pos,
   output logic       mole_change,
   output logic       guess_now,
   output logic       guess_correct,
   output logic       guess_wrong,
   output logic [7:0] score,
   output logic [4:0] seconds,
   output logic       game_over
);

   localparam int unsigned MW = $clog2(MOLE_TICKS + 1);
   localparam int unsigned LW = $clog2(LOCK_TICKS + 1);
   localparam int unsigned SW = $clog2(TICKS_PER_SEC + 1);

   localparam logic [MW-1:0] MOLE_LAST = MW'(MOLE_TICKS - 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TICKS - 1);
   localparam logic [SW-1:0] SEC_LAST  = SW'(TICKS_PER_SEC - 1);
   localparam logic [4:0]    GAME_LEN  = 5'(GAME_SECONDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      LOCK = 2'd2,
      OVER = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    mole_pos_q, mole_pos_d;
   logic [7:0]    score_q, score_d;
   logic [4:0]    seconds_q, seconds_d;
   logic [MW-1:0] mole_cnt_q, mole_cnt_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic [SW-1:0] sec_cnt_q, sec_cnt_d;
   logic          mole_change_q, mole_change_d;
   logic          guess_correct_q, guess_correct_d;
   logic          guess_wrong_q, guess_wrong_d;

   logic          move;
   logic          expire;
   logic [2:0]    reloc_pos;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         mole_pos_q      <= '0;
         score_q         <= '0;
         seconds_q       <= '0;
         mole_cnt_q      <= '0;
         lock_cnt_q      <= '0;
         sec_cnt_q       <= '0;
         mole_change_q   <= 1'b0;
         guess_correct_q <= 1'b0;
         guess_wrong_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         mole_pos_q      <= mole_pos_d;
         score_q         <= score_d;
         seconds_q       <= seconds_d;
         mole_cnt_q      <= mole_cnt_d;
         lock_cnt_q      <= lock_cnt_d;
         sec_cnt_q       <= sec_cnt_d;
         mole_change_q   <= mole_change_d;
         guess_correct_q <= guess_correct_d;
         guess_wrong_q   <= guess_wrong_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      mole_pos_d      = mole_pos_q;
      score_d         = score_q;
      seconds_d       = seconds_q;
      mole_cnt_d      = mole_cnt_q;
      lock_cnt_d      = lock_cnt_q;
      sec_cnt_d       = sec_cnt_q;
      mole_change_d   = 1'b0;
      guess_correct_d = 1'b0;
      guess_wrong_d   = 1'b0;
      move            = 1'b0;
      expire          = 1'b0;
      // The mole must always land somewhere new, so a collision bumps it by one.
      reloc_pos       = (rand_pos == mole_pos_q) ? mole_pos_q + 3'd1 : rand_pos;

      if (restart_game) begin
         state_d       = PLAY;
         score_d       = '0;
         seconds_d     = GAME_LEN;
         mole_pos_d    = rand_pos;
         mole_change_d = 1'b1;
         mole_cnt_d    = '0;
         lock_cnt_d    = '0;
         sec_cnt_d     = '0;
      end else if (state_q == PLAY || state_q == LOCK) begin
         if (tick) begin
            if (mole_cnt_q == MOLE_LAST) begin
               move       = 1'b1;
               mole_cnt_d = '0;
            end else begin
               mole_cnt_d = mole_cnt_q + MW'(1);
            end

            if (sec_cnt_q == SEC_LAST) begin
               sec_cnt_d = '0;
               if (seconds_q != 5'd0) begin
                  seconds_d = seconds_q - 5'd1;
                  expire    = (seconds_q == 5'd1);
               end
            end else begin
               sec_cnt_d = sec_cnt_q + SW'(1);
            end

            if (state_q == LOCK) begin
               if (lock_cnt_q == LOCK_LAST) begin
                  lock_cnt_d = '0;
                  state_d    = PLAY;
               end else begin
                  lock_cnt_d = lock_cnt_q + LW'(1);
               end
            end
         end

         // A correct guess overrides the tick-driven timer so only one move occurs.
         if (state_q == PLAY && eval_now) begin
            if (user_guess == mole_pos_q) begin
               guess_correct_d = 1'b1;
               score_d         = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
               move            = 1'b1;
               mole_cnt_d      = '0;
            end else begin
               guess_wrong_d = 1'b1;
               state_d       = LOCK;
               lock_cnt_d    = '0;
            end
         end

         if (move) begin
            mole_pos_d    = reloc_pos;
            mole_change_d = 1'b1;
         end

         if (expire) begin
            state_d = OVER;
         end
      end
   end

   assign mole_pos      = mole_pos_q;
   assign mole_change   = mole_change_q;
   assign guess_correct = guess_correct_q;
   assign guess_wrong   = guess_wrong_q;
   assign score         = score_q;
   assign seconds       = seconds_q;
   assign guess_now     = (state_q == PLAY);
   assign game_over     = (state_q == OVER);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl with MOLE_TICKS=4, LOCK_TICKS=3,
// TICKS_PER_SEC=2, GAME_SECONDS=5; outputs sampled 1 ns after each rising edge.
module tb_mole_game_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       restart_game = 1'b0;
   logic       eval_now = 1'b0;
   logic [2:0] user_guess = '0;
   logic [2:0] rand_pos = '0;
   logic [2:0] mole_pos;
   logic       mole_change;
   logic       guess_now;
   logic       guess_correct;
   logic       guess_wrong;
   logic [7:0] score;
   logic [4:0] seconds;
   logic       game_over;

   int unsigned vec_cnt = 0;
   int unsigned err_cnt = 0;

   mole_game_ctrl #(
      .MOLE_TICKS   (4),
      .LOCK_TICKS   (3),
      .TICKS_PER_SEC(2),
      .GAME_SECONDS (5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .restart_game (restart_game),
      .eval_now     (eval_now),
      .user_guess   (user_guess),
      .rand_pos     (rand_pos),
      .mole_pos     (mole_pos),
      .mole_change  (mole_change),
      .guess_now    (guess_now),
      .guess_correct(guess_correct),
      .guess_wrong  (guess_wrong),
      .score        (score),
      .seconds      (seconds),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_game(input logic [2:0] r);
      restart_game = 1'b1;
      eval_now     = 1'b0;
      rand_pos     = r;
      step();
      restart_game = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      vec_cnt++; if (mole_pos !== 3'd0) begin err_cnt++; $display("FAIL rst_mole got %0d exp 0", mole_pos); end
      vec_cnt++; if (score !== 8'd0) begin err_cnt++; $display("FAIL rst_score got %0d exp 0", score); end
      vec_cnt++; if (seconds !== 5'd0) begin err_cnt++; $display("FAIL rst_seconds got %0d exp 0", seconds); end
      vec_cnt++; if ({mole_change, guess_correct, guess_wrong, guess_now, game_over} !== 5'b0)
         begin err_cnt++; $display("FAIL rst_flags got %b exp 00000", {mole_change, guess_correct, guess_wrong, guess_now, game_over}); end
      rst = 1'b0;
      step();
      vec_cnt++; if (guess_now !== 1'b0) begin err_cnt++; $display("FAIL idle_hold got %0d exp 0", guess_now); end
   endtask

   task automatic test_relocate();
      tick = 1'b0;
      start_game(3'd3);
      vec_cnt++; if (mole_pos !== 3'd3) begin err_cnt++; $display("FAIL start_mole got %0d exp 3", mole_pos); end
      vec_cnt++; if (mole_change !== 1'b1) begin err_cnt++; $display("FAIL start_change got %0d exp 1", mole_change); end
      vec_cnt++; if (seconds !== 5'd5) begin err_cnt++; $display("FAIL start_seconds got %0d exp 5", seconds); end
      vec_cnt++; if (score !== 8'd0) begin err_cnt++; $display("FAIL start_score got %0d exp 0", score); end
      vec_cnt++; if ({guess_now, game_over} !== 2'b10) begin err_cnt++; $display("FAIL start_state got %b exp 10", {guess_now, game_over}); end
      tick = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         vec_cnt++; if ({mole_change, mole_pos} !== {1'b0, 3'd3})
            begin err_cnt++; $display("FAIL hold_mole%0d got %0d/%0d exp 0/3", i, mole_change, mole_pos); end
      end
      step();
      vec_cnt++; if ({mole_change, mole_pos} !== {1'b1, 3'd4}) begin err_cnt++; $display("FAIL bump_mole got %0d/%0d exp 1/4", mole_change, mole_pos); end
      step();
      vec_cnt++; if (mole_change !== 1'b0) begin err_cnt++; $display("FAIL bump_pulse_width got %0d exp 0", mole_change); end
      rand_pos = 3'd6;
      step();
      step();
      vec_cnt++; if ({mole_change, mole_pos} !== {1'b0, 3'd4}) begin err_cnt++; $display("FAIL pre_move got %0d/%0d exp 0/4", mole_change, mole_pos); end
      step();
      vec_cnt++; if ({mole_change, mole_pos} !== {1'b1, 3'd6}) begin err_cnt++; $display("FAIL move6 got %0d/%0d exp 1/6", mole_change, mole_pos); end
      vec_cnt++; if (seconds !== 5'd1) begin err_cnt++; $display("FAIL reloc_seconds got %0d exp 1", seconds); end
      tick = 1'b0;
   endtask

   task automatic test_correct();
      logic [2:0] exp_mole;
      tick = 1'b1;
      start_game(3'd2);
      step();
      step();
      rand_pos   = 3'd5;
      user_guess = 3'd2;
      eval_now   = 1'b1;
      step();
      eval_now = 1'b0;
      vec_cnt++; if (guess_correct !== 1'b1) begin err_cnt++; $display("FAIL correct_pulse got %0d exp 1", guess_correct); end
      vec_cnt++; if (score !== 8'd1) begin err_cnt++; $display("FAIL correct_score got %0d exp 1", score); end
      vec_cnt++; if ({mole_change, mole_pos} !== {1'b1, 3'd5}) begin err_cnt++; $display("FAIL correct_move got %0d/%0d exp 1/5", mole_change, mole_pos); end
      for (int i = 1; i <= 3; i++) begin
         step();
         vec_cnt++; if ({guess_correct, mole_change} !== 2'b00)
            begin err_cnt++; $display("FAIL timer_restart%0d got %b exp 00", i, {guess_correct, mole_change}); end
      end
      rand_pos = 3'd1;
      step();
      vec_cnt++; if ({mole_change, mole_pos} !== {1'b1, 3'd1}) begin err_cnt++; $display("FAIL timer_move got %0d/%0d exp 1/1", mole_change, mole_pos); end
      vec_cnt++; if (seconds !== 5'd2) begin err_cnt++; $display("FAIL correct_seconds got %0d exp 2", seconds); end

      // With time frozen, 256 correct guesses must saturate the score.
      tick = 1'b0;
      start_game(3'd0);
      exp_mole = 3'd0;
      for (int i = 1; i <= 256; i++) begin
         user_guess = exp_mole;
         rand_pos   = 3'(i * 3);
         eval_now   = 1'b1;
         step();
         exp_mole = (rand_pos == exp_mole) ? exp_mole + 3'd1 : rand_pos;
         vec_cnt++; if ({guess_correct, mole_pos} !== {1'b1, exp_mole})
            begin err_cnt++; $display("FAIL sat_guess%0d got %0d/%0d exp 1/%0d", i, guess_correct, mole_pos, exp_mole); end
      end
      eval_now = 1'b0;
      vec_cnt++; if (score !== 8'd255) begin err_cnt++; $display("FAIL score_sat got %0d exp 255", score); end
   endtask

   task automatic test_wrong_lock();
      tick = 1'b1;
      start_game(3'd2);
      user_guess = 3'd7;
      eval_now   = 1'b1;
      step();
      vec_cnt++; if ({guess_wrong, guess_correct, guess_now} !== 3'b100)
         begin err_cnt++; $display("FAIL wrong_pulse got %b exp 100", {guess_wrong, guess_correct, guess_now}); end
      user_guess = 3'd2;
      step();
      eval_now = 1'b0;
      vec_cnt++; if ({guess_wrong, guess_correct, guess_now} !== 3'b000)
         begin err_cnt++; $display("FAIL lock_ignore got %b exp 000", {guess_wrong, guess_correct, guess_now}); end
      vec_cnt++; if (score !== 8'd0) begin err_cnt++; $display("FAIL lock_score got %0d exp 0", score); end
      step();
      vec_cnt++; if (guess_now !== 1'b0) begin err_cnt++; $display("FAIL lock_tick2 got %0d exp 0", guess_now); end
      step();
      vec_cnt++; if (guess_now !== 1'b1) begin err_cnt++; $display("FAIL lock_exit got %0d exp 1", guess_now); end
      vec_cnt++; if ({mole_change, mole_pos} !== {1'b1, 3'd3}) begin err_cnt++; $display("FAIL lock_mole got %0d/%0d exp 1/3", mole_change, mole_pos); end
      vec_cnt++; if (seconds !== 5'd3) begin err_cnt++; $display("FAIL lock_seconds got %0d exp 3", seconds); end
      tick = 1'b0;
   endtask

   task automatic test_game_over();
      tick = 1'b1;
      start_game(3'd3);
      for (int i = 1; i <= 9; i++) begin
         step();
         vec_cnt++; if ({game_over, seconds} !== {1'b0, 5'(5 - i / 2)})
            begin err_cnt++; $display("FAIL countdown%0d got %0d/%0d exp 0/%0d", i, game_over, seconds, 5 - i / 2); end
      end
      // Correct guess on the expiring edge is still scored.
      user_guess = 3'd3;
      eval_now   = 1'b1;
      step();
      vec_cnt++; if ({game_over, guess_now, seconds} !== {1'b1, 1'b0, 5'd0})
         begin err_cnt++; $display("FAIL expire got %b/%0d exp 10/0", {game_over, guess_now}, seconds); end
      vec_cnt++; if ({guess_correct, score, mole_pos} !== {1'b1, 8'd1, 3'd4})
         begin err_cnt++; $display("FAIL expire_guess got %0d/%0d/%0d exp 1/1/4", guess_correct, score, mole_pos); end
      user_guess = 3'd4;
      for (int i = 1; i <= 5; i++) begin
         step();
         vec_cnt++; if ({game_over, guess_correct, guess_wrong, mole_change, score, seconds, mole_pos} !== {4'b1000, 8'd1, 5'd0, 3'd4})
            begin err_cnt++; $display("FAIL over_hold%0d got %b/%0d/%0d/%0d", i, {game_over, guess_correct, guess_wrong, mole_change}, score, seconds, mole_pos); end
      end
      eval_now = 1'b0;
      start_game(3'd6);
      vec_cnt++; if ({game_over, guess_now, seconds, score, mole_pos} !== {2'b01, 5'd5, 8'd0, 3'd6})
         begin err_cnt++; $display("FAIL over_restart got %b/%0d/%0d/%0d exp 01/5/0/6", {game_over, guess_now}, seconds, score, mole_pos); end
   endtask

   task automatic test_back_to_back();
      // Wrong guess on the expiring edge lands in OVER rather than LOCK.
      tick = 1'b1;
      start_game(3'd1);
      for (int i = 1; i <= 9; i++) step();
      user_guess = 3'd0;
      eval_now   = 1'b1;
      step();
      eval_now = 1'b0;
      vec_cnt++; if ({guess_wrong, game_over} !== 2'b11) begin err_cnt++; $display("FAIL wrong_expire got %b exp 11", {guess_wrong, game_over}); end
      step();
      step();
      step();
      step();
      vec_cnt++; if ({game_over, guess_now} !== 2'b10) begin err_cnt++; $display("FAIL wrong_expire_stay got %b exp 10", {game_over, guess_now}); end

      // Async reset while in LOCK with a pending wrong pulse and nonzero score.
      start_game(3'd1);
      user_guess = 3'd1;
      rand_pos   = 3'd5;
      eval_now   = 1'b1;
      step();
      user_guess = 3'd0;
      step();
      eval_now = 1'b0;
      vec_cnt++; if ({guess_wrong, score} !== {1'b1, 8'd1}) begin err_cnt++; $display("FAIL pre_rst got %0d/%0d exp 1/1", guess_wrong, score); end
      #2 rst = 1'b1;
      #1;
      vec_cnt++; if ({mole_pos, score, seconds} !== {3'd0, 8'd0, 5'd0})
         begin err_cnt++; $display("FAIL async_rst_vals got %0d/%0d/%0d exp 0/0/0", mole_pos, score, seconds); end
      vec_cnt++; if ({mole_change, guess_correct, guess_wrong, guess_now, game_over} !== 5'b0)
         begin err_cnt++; $display("FAIL async_rst_flags got %b exp 00000", {mole_change, guess_correct, guess_wrong, guess_now, game_over}); end
      step();
      rst = 1'b0;

      // Restart wins over a simultaneous eval.
      restart_game = 1'b1;
      eval_now     = 1'b1;
      user_guess   = 3'd0;
      rand_pos     = 3'd4;
      step();
      restart_game = 1'b0;
      eval_now     = 1'b0;
      vec_cnt++; if ({guess_correct, guess_wrong, guess_now, score, mole_pos} !== {3'b001, 8'd0, 3'd4})
         begin err_cnt++; $display("FAIL restart_prio got %b/%0d/%0d exp 001/0/4", {guess_correct, guess_wrong, guess_now}, score, mole_pos); end
      tick = 1'b0;
   endtask

   initial begin
      test_reset();
      test_relocate();
      test_correct();
      test_wrong_lock();
      test_game_over();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
